// File: rtl/idli_sqi_ctrl_m.sv
// rtl/idli_sqi_ctrl_m.sv - SQI memory controller with round-robin fetch/data arbitration
package idli_pkg;
  localparam logic SQI_IO_MODE_OUT = 1'b0;
  localparam logic SQI_IO_MODE_IN  = 1'b1;
endpackage

module idli_sqi_ctrl_m
  import idli_pkg::*;
#(
  parameter int DUMMY_NIB = 2
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic        i_sqi_f_req,
  input  logic [15:0] i_sqi_f_addr,
  output logic        o_sqi_f_gnt,
  output logic [15:0] o_sqi_f_data,
  output logic        o_sqi_f_vld,
  input  logic        i_sqi_d_req,
  input  logic        i_sqi_d_wr,
  input  logic [15:0] i_sqi_d_addr,
  input  logic [15:0] i_sqi_d_wdata,
  output logic        o_sqi_d_gnt,
  output logic [15:0] o_sqi_d_rdata,
  output logic        o_sqi_d_vld,
  output logic        o_sqi_busy,
  output logic        o_sqi_mem_sck,
  output logic        o_sqi_mem_cs,
  output logic        o_sqi_mem_io_mode,
  output logic [3:0]  o_sqi_mem_sio,
  input  logic [3:0]  i_sqi_mem_sio
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIB - 1);

  state_t      state;
  state_t      nxt;
  logic        ph;
  logic [7:0]  cnt;
  logic [47:0] sh;
  logic [47:0] sh_init;
  logic [15:0] rx;
  logic [15:0] rx_next;
  logic        wr;
  logic        own_d;
  logic        last_d;
  logic        gnt_f;
  logic        gnt_d;
  logic        nxt_drive;
  logic        sample;

  // Grant is decided in the IDLE cycle itself; on a tie the requester not served last wins
  assign gnt_f = (state == ST_IDLE) && !i_sqi_rst && i_sqi_f_req && (!i_sqi_d_req || last_d);
  assign gnt_d = (state == ST_IDLE) && !i_sqi_rst && i_sqi_d_req && (!i_sqi_f_req || !last_d);
  assign o_sqi_f_gnt = gnt_f;
  assign o_sqi_d_gnt = gnt_d;

  // Outbound stream: command byte, 24-bit byte address, then write data, MSB nibble first
  assign sh_init = {4'h0, (gnt_d && i_sqi_d_wr) ? 4'h2 : 4'h3, 7'b0,
                    gnt_d ? i_sqi_d_addr : i_sqi_f_addr, 1'b0, i_sqi_d_wdata};

  // Which phase follows the nibble currently on the bus
  always_comb begin
    nxt = state;
    case (state)
      ST_CMD:   if (cnt == 8'd1) nxt = ST_ADDR;
      ST_ADDR:  if (cnt == 8'd5) nxt = (wr || DUMMY_NIB == 0) ? ST_DATA : ST_DUMMY;
      ST_DUMMY: if (cnt == DUMMY_LAST) nxt = ST_DATA;
      ST_DATA:  if (cnt == 8'd3) nxt = ST_DONE;
      default:  nxt = state;
    endcase
  end

  assign nxt_drive = (nxt == ST_CMD) || (nxt == ST_ADDR) || ((nxt == ST_DATA) && wr);
  assign sample    = !wr && ((state == ST_DUMMY) || (state == ST_DATA));
  assign rx_next   = {rx[11:0], i_sqi_mem_sio};

  // Transaction sequencer; every pin and result output is registered here
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state             <= ST_IDLE;
      ph                <= 1'b0;
      cnt               <= 8'd0;
      sh                <= 48'd0;
      rx                <= 16'd0;
      wr                <= 1'b0;
      own_d             <= 1'b0;
      last_d            <= 1'b1;
      o_sqi_mem_cs      <= 1'b1;
      o_sqi_mem_sck     <= 1'b0;
      o_sqi_mem_io_mode <= SQI_IO_MODE_OUT;
      o_sqi_mem_sio     <= 4'h0;
      o_sqi_f_vld       <= 1'b0;
      o_sqi_d_vld       <= 1'b0;
      o_sqi_f_data      <= 16'd0;
      o_sqi_d_rdata     <= 16'd0;
      o_sqi_busy        <= 1'b0;
    end else begin
      o_sqi_f_vld <= 1'b0;
      o_sqi_d_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_f || gnt_d) begin
            state             <= ST_CMD;
            ph                <= 1'b0;
            cnt               <= 8'd0;
            own_d             <= gnt_d;
            last_d            <= gnt_d;
            wr                <= gnt_d && i_sqi_d_wr;
            o_sqi_mem_sio     <= sh_init[47:44];
            sh                <= {sh_init[43:0], 4'h0};
            o_sqi_mem_cs      <= 1'b0;
            o_sqi_mem_sck     <= 1'b0;
            o_sqi_mem_io_mode <= SQI_IO_MODE_OUT;
            o_sqi_busy        <= 1'b1;
          end
        end
        ST_DONE: begin
          if (cnt == 8'd1) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            o_sqi_busy <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          if (!ph) begin
            ph            <= 1'b1;
            o_sqi_mem_sck <= 1'b1;
          end else begin
            ph            <= 1'b0;
            o_sqi_mem_sck <= 1'b0;
            if (sample) rx <= rx_next;
            state <= nxt;
            cnt   <= (nxt != state) ? 8'd0 : cnt + 8'd1;
            if (nxt == ST_DONE) begin
              o_sqi_mem_cs      <= 1'b1;
              o_sqi_mem_io_mode <= SQI_IO_MODE_OUT;
              o_sqi_mem_sio     <= 4'h0;
              if (wr) begin
                o_sqi_d_vld <= 1'b1;
              end else if (own_d) begin
                o_sqi_d_vld   <= 1'b1;
                o_sqi_d_rdata <= rx_next;
              end else begin
                o_sqi_f_vld  <= 1'b1;
                o_sqi_f_data <= rx_next;
              end
            end else if (nxt_drive) begin
              o_sqi_mem_io_mode <= SQI_IO_MODE_OUT;
              o_sqi_mem_sio     <= sh[47:44];
              sh                <= {sh[43:0], 4'h0};
            end else begin
              o_sqi_mem_io_mode <= SQI_IO_MODE_IN;
              o_sqi_mem_sio     <= 4'h0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb/tb_idli_sqi_ctrl_m.sv - scoreboard bench for idli_sqi_ctrl_m with an SQI memory model
module tb_idli_sqi_ctrl_m;
  import idli_pkg::*;

  localparam int D = 2;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [15:0] f_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [3:0]  mem_sio;
  logic        o_sqi_f_gnt;
  logic [15:0] o_sqi_f_data;
  logic        o_sqi_f_vld;
  logic        o_sqi_d_gnt;
  logic [15:0] o_sqi_d_rdata;
  logic        o_sqi_d_vld;
  logic        o_sqi_busy;
  logic        o_sqi_mem_sck;
  logic        o_sqi_mem_cs;
  logic        o_sqi_mem_io_mode;
  logic [3:0]  o_sqi_mem_sio;

  idli_sqi_ctrl_m #(.DUMMY_NIB(D)) dut (
    .i_sqi_gck(clk),
    .i_sqi_rst(rst),
    .i_sqi_f_req(f_req),
    .i_sqi_f_addr(f_addr),
    .o_sqi_f_gnt(o_sqi_f_gnt),
    .o_sqi_f_data(o_sqi_f_data),
    .o_sqi_f_vld(o_sqi_f_vld),
    .i_sqi_d_req(d_req),
    .i_sqi_d_wr(d_wr),
    .i_sqi_d_addr(d_addr),
    .i_sqi_d_wdata(d_wdata),
    .o_sqi_d_gnt(o_sqi_d_gnt),
    .o_sqi_d_rdata(o_sqi_d_rdata),
    .o_sqi_d_vld(o_sqi_d_vld),
    .o_sqi_busy(o_sqi_busy),
    .o_sqi_mem_sck(o_sqi_mem_sck),
    .o_sqi_mem_cs(o_sqi_mem_cs),
    .o_sqi_mem_io_mode(o_sqi_mem_io_mode),
    .o_sqi_mem_sio(o_sqi_mem_sio),
    .i_sqi_mem_sio(mem_sio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] data;
    int          at;
  } exp_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] ba;
  } hdr_t;

  exp_t sb_q[$];
  hdr_t mm_q[$];

  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] sqi_mem [logic [15:0]];

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Arbiter/timing reference: when the controller should be free and who should win
  int free_at = 0;
  int last_g = -1;
  bit last_d = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      free_at = cyc + 1;
      last_g  = -1;
      last_d  = 1'b1;
      sb_q.delete();
      mm_q.delete();
    end else begin
      bit idle;
      bit ef;
      bit ed;
      idle = (cyc >= free_at);
      ef = idle && f_req && (!d_req || last_d);
      ed = idle && d_req && (!f_req || !last_d);
      chk("f_gnt", 32'(o_sqi_f_gnt), 32'(ef));
      chk("d_gnt", 32'(o_sqi_d_gnt), 32'(ed));
      chk("busy", 32'(o_sqi_busy), 32'((cyc > last_g) && (cyc < free_at)));
      if (ef || ed) begin
        exp_t e;
        hdr_t h;
        logic [15:0] a;
        a = ed ? d_addr : f_addr;
        e.is_d = ed;
        e.wr = ed && d_wr;
        if (e.wr) begin
          ref_mem[a] = d_wdata;
          e.data = 16'h0;
        end else begin
          e.data = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        end
        e.at = cyc + (e.wr ? 25 : 25 + 2 * D);
        sb_q.push_back(e);
        h.cmd = e.wr ? 8'h02 : 8'h03;
        h.ba = {7'b0, a, 1'b0};
        mm_q.push_back(h);
        free_at = e.at + 2;
        last_g = cyc;
        last_d = ed;
      end
    end
  end

  // Result monitor: pops the scoreboard whenever a valid pulse appears
  logic [15:0] exp_f_data = 16'h0;
  logic [15:0] exp_d_rdata = 16'h0;

  always @(negedge clk) begin
    if (rst) begin
      exp_f_data = 16'h0;
      exp_d_rdata = 16'h0;
    end else begin
      if (o_sqi_f_vld || o_sqi_d_vld) begin
        if (sb_q.size() == 0) begin
          chk("vld_unexpected", {30'd0, o_sqi_f_vld, o_sqi_d_vld}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("vld_owner_d", 32'(o_sqi_d_vld), 32'(e.is_d));
          chk("vld_owner_f", 32'(o_sqi_f_vld), 32'(!e.is_d));
          chk("vld_cycle", cyc, e.at);
          if (!e.wr) begin
            if (e.is_d) exp_d_rdata = e.data;
            else exp_f_data = e.data;
          end
        end
      end
      chk("f_data", 32'(o_sqi_f_data), 32'(exp_f_data));
      chk("d_rdata", 32'(o_sqi_d_rdata), 32'(exp_d_rdata));
    end
  end

  // SQI memory model: decodes outbound nibbles and answers reads
  int k = 0;
  int hp = 0;
  bit is_rd = 1'b0;
  logic [3:0]  nib [0:15];
  logic [23:0] ba;
  logic [15:0] rd_word;

  always @(negedge clk) begin
    if (rst) begin
      k = 0;
      hp = 0;
      is_rd = 1'b0;
    end else if (o_sqi_mem_cs) begin
      k = 0;
      hp = 0;
      is_rd = 1'b0;
      mem_sio = 4'($urandom);
      chk("idle_sck", 32'(o_sqi_mem_sck), 32'd0);
      chk("idle_io_mode", 32'(o_sqi_mem_io_mode), 32'(SQI_IO_MODE_OUT));
      chk("idle_sio", 32'(o_sqi_mem_sio), 32'd0);
    end else begin
      chk("sck_phase", 32'(o_sqi_mem_sck), 32'(hp % 2));
      chk("io_mode", 32'(o_sqi_mem_io_mode),
          32'((is_rd && k >= 8) ? SQI_IO_MODE_IN : SQI_IO_MODE_OUT));
      if (is_rd && k >= 8) chk("rd_sio_zero", 32'(o_sqi_mem_sio), 32'd0);
      if (!o_sqi_mem_sck) begin
        if (is_rd && k >= 8 + D && k < 12 + D)
          mem_sio = 4'(rd_word >> (4 * (11 + D - k)));
        else
          mem_sio = 4'($urandom);
      end else begin
        if (k < 16) nib[k] = o_sqi_mem_sio;
        k++;
        if (k == 2) is_rd = ({nib[0], nib[1]} == 8'h03);
        if (k == 8) begin
          ba = {nib[2], nib[3], nib[4], nib[5], nib[6], nib[7]};
          if (mm_q.size() == 0) begin
            chk("hdr_unexpected", 32'd1, 32'd0);
          end else begin
            hdr_t h;
            h = mm_q.pop_front();
            chk("cmd", 32'({nib[0], nib[1]}), 32'(h.cmd));
            chk("addr", 32'(ba), 32'(h.ba));
          end
          rd_word = sqi_mem.exists(ba[16:1]) ? sqi_mem[ba[16:1]] : dflt(ba[16:1]);
        end
        if (!is_rd && k == 12) sqi_mem[ba[16:1]] = {nib[8], nib[9], nib[10], nib[11]};
      end
      hp++;
    end
  end

  task automatic do_f(input logic [15:0] a, input bit hold);
    bit got;
    got = 1'b0;
    f_addr = a;
    f_req = 1'b1;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = o_sqi_f_gnt;
    end
    if (!got) chk("f_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) f_req = 1'b0;
    f_addr = 16'($urandom);
  endtask

  task automatic do_d(input logic [15:0] a, input bit w, input logic [15:0] wd, input bit hold);
    bit got;
    got = 1'b0;
    d_addr = a;
    d_wr = w;
    d_wdata = wd;
    d_req = 1'b1;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = o_sqi_d_gnt;
    end
    if (!got) chk("d_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) d_req = 1'b0;
    d_addr = 16'($urandom);
    d_wr = 1'($urandom);
    d_wdata = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || o_sqi_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 2000), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    f_req = 1'b0;
    d_req = 1'b0;
    f_addr = 16'h0;
    d_addr = 16'h0;
    d_wr = 1'b0;
    d_wdata = 16'h0;
    mem_sio = 4'h0;
    ref_mem[16'h1234] = 16'hBEEF;
    sqi_mem[16'h1234] = 16'hBEEF;
    ref_mem[16'hFFFF] = 16'h0001;
    sqi_mem[16'hFFFF] = 16'h0001;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", 32'(o_sqi_mem_cs), 32'd1);
    chk("rst_sck", 32'(o_sqi_mem_sck), 32'd0);
    chk("rst_io_mode", 32'(o_sqi_mem_io_mode), 32'(SQI_IO_MODE_OUT));
    chk("rst_sio", 32'(o_sqi_mem_sio), 32'd0);
    chk("rst_busy", 32'(o_sqi_busy), 32'd0);
    chk("rst_vld", {30'd0, o_sqi_f_vld, o_sqi_d_vld}, 32'd0);
    chk("rst_data", {o_sqi_f_data, o_sqi_d_rdata}, 32'd0);

    // Tie straight out of reset: fetch first, then the write
    @(posedge clk);
    #1;
    rst = 1'b0;
    fork
      do_f(16'h1234, 1'b0);
      do_d(16'h0001, 1'b1, 16'hA5C3, 1'b0);
    join
    drain();
    do_d(16'hFFFF, 1'b0, 16'h0000, 1'b0);
    drain();
    do_f(16'h0001, 1'b0);
    drain();

    // Both requesters competing with random gaps, small address range to reuse writes
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 40)) @(posedge clk);
          #1;
          do_f(16'($urandom_range(0, 15)), 1'b0);
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 40)) @(posedge clk);
          #1;
          do_d(16'($urandom_range(0, 15)), 1'($urandom), 16'($urandom), 1'b0);
        end
      end
    join
    drain();

    // Continuous contention alternates grants
    fork
      for (int i = 0; i < 3; i++) do_f(16'($urandom_range(0, 15)), 1'b1);
      for (int i = 0; i < 3; i++) do_d(16'($urandom_range(0, 15)), 1'($urandom), 16'($urandom), 1'b1);
    join
    f_req = 1'b0;
    d_req = 1'b0;
    drain();

    // Reset in the middle of a read with the request still held
    do_f(16'h0042, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cs", 32'(o_sqi_mem_cs), 32'd1);
    chk("abort_sck", 32'(o_sqi_mem_sck), 32'd0);
    chk("abort_io_mode", 32'(o_sqi_mem_io_mode), 32'(SQI_IO_MODE_OUT));
    chk("abort_busy", 32'(o_sqi_busy), 32'd0);
    chk("abort_vld", {30'd0, o_sqi_f_vld, o_sqi_d_vld}, 32'd0);
    chk("abort_regrant", 32'(o_sqi_f_gnt), 32'd1);
    @(posedge clk);
    #1;
    f_req = 1'b0;
    drain();

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
